// File: rtl/lsu_stbuf_pkg.sv
// Shared types and sizing for the DCCM committed-store buffer.
// Entry layout is fixed here so the top and the forwarding selector agree.
// No logic; constants and the entry record only.
package lsu_stbuf_pkg;

   localparam int STBUF_DEPTH = 4;
   localparam int DCCM_ADDR_W = 16;
   localparam int DCCM_DATA_W = 39;
   localparam int PTR_W       = $clog2(STBUF_DEPTH);
   localparam int CNT_W       = PTR_W + 1;

   typedef struct packed {
      logic                   vld;
      logic [DCCM_ADDR_W-1:2] waddr;
      logic [DCCM_DATA_W-1:0] data;
   } stbuf_entry_t;

endpackage

// File: rtl/lsu_stbuf_fwd_sel.sv
// Youngest-match select over buffered entries plus the incoming store word.
// Latency: purely combinational.
// Backpressure: none; evaluated every cycle regardless of freeze.
module lsu_stbuf_fwd_sel
   import lsu_stbuf_pkg::*;
(
   input  stbuf_entry_t           entries [STBUF_DEPTH],
   input  logic [PTR_W-1:0]       rd_ptr,
   input  logic                   in_vld,
   input  logic [DCCM_ADDR_W-1:2] in_waddr,
   input  logic [DCCM_DATA_W-1:0] in_data,
   input  logic [DCCM_ADDR_W-1:2] ld_waddr,
   output logic                   hit,
   output logic [DCCM_DATA_W-1:0] data
);

   logic [PTR_W-1:0] idx;

   // Walk oldest to youngest from the head; each later match overrides, incoming store last.
   always_comb begin
      hit  = 1'b0;
      data = '0;
      idx  = '0;
      for (int k = 0; k < STBUF_DEPTH; k++) begin
         idx = rd_ptr + PTR_W'(k);
         if (entries[idx].vld && (entries[idx].waddr == ld_waddr)) begin
            hit  = 1'b1;
            data = entries[idx].data;
         end
      end
      if (in_vld && (in_waddr == ld_waddr)) begin
         hit  = 1'b1;
         data = in_data;
      end
   end

endmodule

// File: rtl/lsu_dccm_stbuf.sv
// In-order committed-store buffer draining one ECC word per cycle into the DCCM write port.
// Latency: push at edge N can write the DCCM in cycle N+1; forwarding is same-cycle.
// Backpressure: st_ready drops when full or frozen; loads win the port unless the buffer is full.
module lsu_dccm_stbuf
   import lsu_stbuf_pkg::*;
#(
   parameter int DEPTH  = STBUF_DEPTH,
   parameter int ADDR_W = DCCM_ADDR_W,
   parameter int DATA_W = DCCM_DATA_W
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     lsu_freeze_dc3,
   input  logic                     st_valid,
   input  logic [ADDR_W-1:0]        st_addr,
   input  logic [DATA_W-1:0]        st_data,
   output logic                     st_ready,
   input  logic                     ld_rden,
   input  logic [ADDR_W-1:0]        ld_addr_lo,
   input  logic [ADDR_W-1:0]        ld_addr_hi,
   output logic                     ld_block,
   output logic                     fwd_hit_lo,
   output logic                     fwd_hit_hi,
   output logic [DATA_W-1:0]        fwd_data_lo,
   output logic [DATA_W-1:0]        fwd_data_hi,
   output logic                     dccm_wren,
   output logic [ADDR_W-1:0]        dccm_wr_addr,
   output logic [DATA_W-1:0]        dccm_wr_data,
   output logic                     stbuf_empty,
   output logic [$clog2(DEPTH):0]   stbuf_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   stbuf_entry_t      entries [DEPTH];
   stbuf_entry_t      head;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [CW-1:0]     count;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic              hit_lo_raw;
   logic              hit_hi_raw;
   logic [DATA_W-1:0] data_lo_raw;
   logic [DATA_W-1:0] data_hi_raw;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign st_ready = ~full & ~lsu_freeze_dc3;
   // Reset cycle neither accepts nor drains, so stale entries can never leak out.
   assign push     = st_valid & st_ready & ~rst;
   assign pop      = ~empty & ~lsu_freeze_dc3 & (~ld_rden | full) & ~rst;
   // A load only loses the port when a full buffer forces a drain.
   assign ld_block = pop & ld_rden;

   assign head         = entries[rd_ptr];
   assign dccm_wren    = pop;
   assign dccm_wr_addr = {head.waddr, 2'b00};
   assign dccm_wr_data = head.data;
   assign stbuf_empty  = empty;
   assign stbuf_count  = count;

   // Pointers, occupancy and entry storage; popped entries lose valid so they stop forwarding.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            entries[i] <= '0;
         end
      end else begin
         if (push) begin
            entries[wr_ptr] <= '{vld: 1'b1, waddr: st_addr[ADDR_W-1:2], data: st_data};
            wr_ptr          <= wr_ptr + 1'b1;
         end
         if (pop) begin
            entries[rd_ptr].vld <= 1'b0;
            rd_ptr              <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            count <= count + 1'b1;
         end else if (pop && !push) begin
            count <= count - 1'b1;
         end
      end
   end

   lsu_stbuf_fwd_sel u_fwd_lo (
      .entries  (entries),
      .rd_ptr   (rd_ptr),
      .in_vld   (push),
      .in_waddr (st_addr[ADDR_W-1:2]),
      .in_data  (st_data),
      .ld_waddr (ld_addr_lo[ADDR_W-1:2]),
      .hit      (hit_lo_raw),
      .data     (data_lo_raw)
   );

   lsu_stbuf_fwd_sel u_fwd_hi (
      .entries  (entries),
      .rd_ptr   (rd_ptr),
      .in_vld   (push),
      .in_waddr (st_addr[ADDR_W-1:2]),
      .in_data  (st_data),
      .ld_waddr (ld_addr_hi[ADDR_W-1:2]),
      .hit      (hit_hi_raw),
      .data     (data_hi_raw)
   );

   assign fwd_hit_lo  = hit_lo_raw & ~rst;
   assign fwd_hit_hi  = hit_hi_raw & ~rst;
   assign fwd_data_lo = rst ? '0 : data_lo_raw;
   assign fwd_data_hi = rst ? '0 : data_hi_raw;

   // Commit must honour st_ready; occupancy must stay within bounds.
   a_no_drop: assert property (@(posedge clk) disable iff (rst) !(st_valid && !st_ready));
   a_no_ovf:  assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));
   a_no_unf:  assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: tb/tb_lsu_dccm_stbuf.sv
// Self-checking bench: directed vector table for the corner cases, then random traffic vs a queue model.
module tb_lsu_dccm_stbuf;
   import lsu_stbuf_pkg::*;

   localparam int AW = DCCM_ADDR_W;
   localparam int DW = DCCM_DATA_W;
   localparam logic [AW-1:0] NA = 16'h0F00;

   logic          clk = 1'b0;
   logic          rst, lsu_freeze_dc3, st_valid, ld_rden;
   logic [AW-1:0] st_addr, ld_addr_lo, ld_addr_hi;
   logic [DW-1:0] st_data;
   logic          st_ready, ld_block, fwd_hit_lo, fwd_hit_hi, dccm_wren, stbuf_empty;
   logic [DW-1:0] fwd_data_lo, fwd_data_hi, dccm_wr_data;
   logic [AW-1:0] dccm_wr_addr;
   logic [PTR_W:0] stbuf_count;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lsu_dccm_stbuf dut (
      .clk(clk), .rst(rst), .lsu_freeze_dc3(lsu_freeze_dc3),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
      .ld_rden(ld_rden), .ld_addr_lo(ld_addr_lo), .ld_addr_hi(ld_addr_hi), .ld_block(ld_block),
      .fwd_hit_lo(fwd_hit_lo), .fwd_hit_hi(fwd_hit_hi),
      .fwd_data_lo(fwd_data_lo), .fwd_data_hi(fwd_data_hi),
      .dccm_wren(dccm_wren), .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
      .stbuf_empty(stbuf_empty), .stbuf_count(stbuf_count)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic          rst, frz, stv;
      logic [AW-1:0] sta;
      logic [DW-1:0] std;
      logic          ldr;
      logic [AW-1:0] lo, hi;
      logic          wren;
      logic [AW-1:0] waddr;
      logic [DW-1:0] wdat;
      logic          blk, hlo;
      logic [DW-1:0] dlo;
      logic          hhi;
      logic [DW-1:0] dhi;
      int            cnt;
      logic          rdy;
   } vec_t;

   function automatic vec_t mk(input logic r, f, sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                               input logic lr, input logic [AW-1:0] l, h,
                               input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic bk, hl, input logic [DW-1:0] dl,
                               input logic hh, input logic [DW-1:0] dh, input int c, input logic rd);
      vec_t v;
      v.rst = r; v.frz = f; v.stv = sv; v.sta = sa; v.std = sd; v.ldr = lr; v.lo = l; v.hi = h;
      v.wren = we; v.waddr = wa; v.wdat = wd; v.blk = bk; v.hlo = hl; v.dlo = dl;
      v.hhi = hh; v.dhi = dh; v.cnt = c; v.rdy = rd;
      return v;
   endfunction

   task automatic drive(input logic r, f, sv, input logic [AW-1:0] sa, input logic [DW-1:0] sd,
                        input logic lr, input logic [AW-1:0] l, h);
      rst = r; lsu_freeze_dc3 = f; st_valid = sv; st_addr = sa; st_data = sd;
      ld_rden = lr; ld_addr_lo = l; ld_addr_hi = h;
   endtask

   typedef struct {
      logic [AW-1:2] w;
      logic [DW-1:0] d;
   } ment_t;

   vec_t  tbl[$];
   ment_t q[$];

   initial begin
      drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, NA, NA);
      repeat (2) @(posedge clk);
      #1;

      // reset state
      tbl.push_back(mk(1,0,0,16'h0,39'h0,0,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 0,1));
      // single push drains next cycle when no load
      tbl.push_back(mk(0,0,1,16'h0100,39'h1,0,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 0,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,0,NA,NA, 1,16'h0100,39'h1,0, 0,39'h0,0,39'h0, 1,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,0,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 0,1));
      // fill under continuous loads, then forced drain with ld_block
      tbl.push_back(mk(0,0,1,16'h0400,39'h11,1,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 0,1));
      tbl.push_back(mk(0,0,1,16'h0404,39'h12,1,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 1,1));
      tbl.push_back(mk(0,0,1,16'h0408,39'h13,1,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 2,1));
      tbl.push_back(mk(0,0,1,16'h040C,39'h14,1,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 3,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,1,NA,NA, 1,16'h0400,39'h11,1, 0,39'h0,0,39'h0, 4,0));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,1,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 3,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,0,NA,NA, 1,16'h0404,39'h12,0, 0,39'h0,0,39'h0, 3,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,0,NA,NA, 1,16'h0408,39'h13,0, 0,39'h0,0,39'h0, 2,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,0,NA,NA, 1,16'h040C,39'h14,0, 0,39'h0,0,39'h0, 1,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,0,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 0,1));
      // two stores to one word: youngest forwards, hi independent
      tbl.push_back(mk(0,0,1,16'h0200,39'h21,1,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 0,1));
      tbl.push_back(mk(0,0,1,16'h0200,39'h22,1,16'h0202,16'h0204, 0,16'h0,39'h0,0, 1,39'h22,0,39'h0, 1,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,1,16'h0202,16'h0204, 0,16'h0,39'h0,0, 1,39'h22,0,39'h0, 2,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,1,16'h0204,16'h0201, 0,16'h0,39'h0,0, 0,39'h0,1,39'h22, 2,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,0,NA,NA, 1,16'h0200,39'h21,0, 0,39'h0,0,39'h0, 2,1));
      // entry being popped still forwards
      tbl.push_back(mk(0,0,0,16'h0,39'h0,0,16'h0200,NA, 1,16'h0200,39'h22,0, 1,39'h22,0,39'h0, 1,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,0,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 0,1));
      // same-cycle incoming store forwards into an empty buffer
      tbl.push_back(mk(0,0,1,16'h0300,39'h33,1,16'h0300,NA, 0,16'h0,39'h0,0, 1,39'h33,0,39'h0, 0,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,0,NA,NA, 1,16'h0300,39'h33,0, 0,39'h0,0,39'h0, 1,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,0,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 0,1));
      // freeze holds everything, reset mid-freeze discards entries
      tbl.push_back(mk(0,0,1,16'h0500,39'h51,1,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 0,1));
      tbl.push_back(mk(0,0,1,16'h0504,39'h52,1,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 1,1));
      tbl.push_back(mk(0,1,0,16'h0,39'h0,0,16'h0504,NA, 0,16'h0,39'h0,0, 1,39'h52,0,39'h0, 2,0));
      tbl.push_back(mk(0,1,0,16'h0,39'h0,0,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 2,0));
      tbl.push_back(mk(1,1,0,16'h0,39'h0,0,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 2,0));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,0,16'h0500,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 0,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,0,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 0,1));
      // reset while a drain would otherwise happen
      tbl.push_back(mk(0,0,1,16'h0600,39'h61,1,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 0,1));
      tbl.push_back(mk(1,0,0,16'h0,39'h0,0,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 1,1));
      tbl.push_back(mk(0,0,0,16'h0,39'h0,0,NA,NA, 0,16'h0,39'h0,0, 0,39'h0,0,39'h0, 0,1));

      foreach (tbl[i]) begin
         vec_t v;
         v = tbl[i];
         drive(v.rst, v.frz, v.stv, v.sta, v.std, v.ldr, v.lo, v.hi);
         @(negedge clk);
         chk($sformatf("v%0d.wren", i), dccm_wren, v.wren);
         if (v.wren) begin
            chk($sformatf("v%0d.waddr", i), dccm_wr_addr, v.waddr);
            chk($sformatf("v%0d.wdata", i), dccm_wr_data, v.wdat);
         end
         chk($sformatf("v%0d.ld_block", i), ld_block, v.blk);
         chk($sformatf("v%0d.hit_lo", i), fwd_hit_lo, v.hlo);
         chk($sformatf("v%0d.data_lo", i), fwd_data_lo, v.dlo);
         chk($sformatf("v%0d.hit_hi", i), fwd_hit_hi, v.hhi);
         chk($sformatf("v%0d.data_hi", i), fwd_data_hi, v.dhi);
         chk($sformatf("v%0d.count", i), stbuf_count, v.cnt);
         chk($sformatf("v%0d.empty", i), stbuf_empty, v.cnt == 0);
         chk($sformatf("v%0d.st_ready", i), st_ready, v.rdy);
         @(posedge clk);
         #1;
      end

      // random traffic against an in-order queue model
      drive(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, NA, NA);
      @(posedge clk);
      #1;
      q.delete();
      for (int n = 0; n < 3000; n++) begin
         logic          r, f, lr, sv, rdy_m, full_m, pop_m, push_m, hl, hh;
         logic [AW-1:0] sa, lo, hi;
         logic [DW-1:0] sd, dl, dh;
         r      = ($urandom_range(0, 199) == 0);
         f      = ($urandom_range(0, 11) == 0);
         lr     = ($urandom_range(0, 1) == 1);
         full_m = (q.size() == STBUF_DEPTH);
         rdy_m  = !full_m && !f;
         sv     = rdy_m && ($urandom_range(0, 2) != 0);
         sa     = 16'h0100 | AW'($urandom_range(0, 7) << 2) | AW'($urandom_range(0, 3));
         sd     = {7'($urandom()), $urandom()};
         lo     = 16'h0100 | AW'($urandom_range(0, 7) << 2) | AW'($urandom_range(0, 3));
         hi     = 16'h0100 | AW'($urandom_range(0, 7) << 2) | AW'($urandom_range(0, 3));
         pop_m  = !r && (q.size() > 0) && !f && (!lr || full_m);
         push_m = !r && sv && rdy_m;
         hl = 1'b0; dl = '0; hh = 1'b0; dh = '0;
         if (!r) begin
            foreach (q[k]) begin
               if (q[k].w == lo[AW-1:2]) begin hl = 1'b1; dl = q[k].d; end
               if (q[k].w == hi[AW-1:2]) begin hh = 1'b1; dh = q[k].d; end
            end
            if (push_m && sa[AW-1:2] == lo[AW-1:2]) begin hl = 1'b1; dl = sd; end
            if (push_m && sa[AW-1:2] == hi[AW-1:2]) begin hh = 1'b1; dh = sd; end
         end
         drive(r, f, sv, sa, sd, lr, lo, hi);
         @(negedge clk);
         chk("rnd.wren", dccm_wren, pop_m);
         if (pop_m) begin
            chk("rnd.waddr", dccm_wr_addr, {q[0].w, 2'b00});
            chk("rnd.wdata", dccm_wr_data, q[0].d);
         end
         chk("rnd.ld_block", ld_block, pop_m && lr);
         chk("rnd.count", stbuf_count, q.size());
         chk("rnd.empty", stbuf_empty, q.size() == 0);
         chk("rnd.st_ready", st_ready, rdy_m);
         chk("rnd.hit_lo", fwd_hit_lo, hl);
         chk("rnd.data_lo", fwd_data_lo, dl);
         chk("rnd.hit_hi", fwd_hit_hi, hh);
         chk("rnd.data_hi", fwd_data_hi, dh);
         @(posedge clk);
         #1;
         if (r) begin
            q.delete();
         end else begin
            if (pop_m) void'(q.pop_front());
            if (push_m) q.push_back('{w: sa[AW-1:2], d: sd});
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
